// File: rtl/buf_bank_seq_if.sv
// Request/status bundle between a power controller and the buffer-bank sequencer.
// The master drives the requests and the step delay; the slave returns the registered bank status.
interface buf_bank_seq_if #(
   parameter int NSEG = 8,
   parameter int DLYW = 4
);
   localparam int LW = $clog2(NSEG + 1);

   logic            req_on;
   logic            req_off;
   logic [DLYW-1:0] step_dly;
   logic [NSEG-1:0] en;
   logic [LW-1:0]   level;
   logic            busy;
   logic            ready;

   modport master (
      output req_on, req_off, step_dly,
      input  en, level, busy, ready
   );

   modport slave (
      input  req_on, req_off, step_dly,
      output en, level, busy, ready
   );
endinterface

// File: rtl/buf_bank_seq.sv
// Buffer-bank power sequencer: ramps a thermometer enable one segment per STEP_DLY+1 cycles.
// All outputs are registered (one edge from request to first effect); requests are level signals with no backpressure.
module buf_bank_seq #(
   parameter int NSEG = 8,
   parameter int DLYW = 4
) (
   input  logic           clk,
   input  logic           rstn,
   buf_bank_seq_if.slave  bus
);
   localparam int LW = $clog2(NSEG + 1);

   typedef enum logic [1:0] {
      S_OFF     = 2'd0,
      S_RAMP_UP = 2'd1,
      S_ON      = 2'd2,
      S_RAMP_DN = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_nxt;
   logic [NSEG-1:0] en_q;
   logic [NSEG-1:0] en_nxt;
   logic [DLYW-1:0] cnt_q;
   logic [DLYW-1:0] cnt_nxt;
   logic [LW-1:0]   level_q;
   logic            busy_q;
   logic            ready_q;
   logic            cmd_on;
   logic            cmd_off;
   logic            conflict;

   function automatic logic [LW-1:0] popcnt(input logic [NSEG-1:0] v);
      logic [LW-1:0] acc;
      acc = '0;
      for (int i = 0; i < NSEG; i++) begin
         acc = acc + LW'(v[i]);
      end
      return acc;
   endfunction

   assign conflict = bus.req_on & bus.req_off;
   assign cmd_on   = bus.req_on & ~bus.req_off;
   assign cmd_off  = bus.req_off & ~bus.req_on;

   always_comb begin
      state_nxt = state_q;
      en_nxt    = en_q;
      cnt_nxt   = cnt_q;
      // Simultaneous on/off freezes everything, including the delay counter.
      if (!conflict) begin
         case (state_q)
            S_OFF: begin
               if (cmd_on) begin
                  state_nxt = S_RAMP_UP;
                  en_nxt    = NSEG'(1);
                  cnt_nxt   = bus.step_dly;
               end
            end
            S_RAMP_UP: begin
               if (cmd_off) begin
                  state_nxt = S_RAMP_DN;
                  cnt_nxt   = bus.step_dly;
               end else if (cnt_q != '0) begin
                  cnt_nxt = cnt_q - DLYW'(1);
               end else begin
                  en_nxt  = {en_q[NSEG-2:0], 1'b1};
                  cnt_nxt = bus.step_dly;
                  if (en_nxt == '1) begin
                     state_nxt = S_ON;
                  end
               end
            end
            S_ON: begin
               if (cmd_off) begin
                  state_nxt = S_RAMP_DN;
                  cnt_nxt   = bus.step_dly;
               end
            end
            S_RAMP_DN: begin
               if (cmd_on) begin
                  state_nxt = S_RAMP_UP;
                  cnt_nxt   = bus.step_dly;
               end else if (cnt_q != '0) begin
                  cnt_nxt = cnt_q - DLYW'(1);
               end else begin
                  en_nxt  = en_q >> 1;
                  cnt_nxt = bus.step_dly;
                  if (en_nxt == '0) begin
                     state_nxt = S_OFF;
                  end
               end
            end
            default: begin
               state_nxt = S_OFF;
               en_nxt    = '0;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Status flags are computed from the next state so they line up with en_q.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_OFF;
         en_q    <= '0;
         cnt_q   <= '0;
         level_q <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         en_q    <= en_nxt;
         cnt_q   <= cnt_nxt;
         level_q <= popcnt(en_nxt);
         busy_q  <= (state_nxt == S_RAMP_UP) || (state_nxt == S_RAMP_DN);
         ready_q <= (state_nxt == S_ON);
      end
   end

   assign bus.en    = en_q;
   assign bus.level = level_q;
   assign bus.busy  = busy_q;
   assign bus.ready = ready_q;
endmodule
